// File: rtl/seg_scan_ctrl.sv
// Seven-segment digit scanner: rotates a one-cold active-low anode select over the
// enabled digits, with optional blanking between digits and a digit-data mux.
//
// state | meaning
// OFF   | all anodes off; seeks the first enabled digit from digit_idx
// SHOW  | anode digit_idx driven; tickin advances to the next enabled digit
// BLANK | all anodes off for BLANK_CYCLES clocks before showing the held next digit
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int DATA_W       = 4,
  parameter int BLANK_CYCLES = 0,
  localparam int IDX_W       = $clog2(NUM_DIGITS),
  localparam int CNT_W       = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tickin,
  input  logic                           dir,
  input  logic [NUM_DIGITS-1:0]          digit_en,
  input  logic [NUM_DIGITS*DATA_W-1:0]   digits,
  output logic [NUM_DIGITS-1:0]          shift,
  output logic [IDX_W-1:0]               digit_idx,
  output logic [DATA_W-1:0]              cur_data,
  output logic                           frame_done
);

  typedef enum logic [1:0] {OFF, SHOW, BLANK} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        nxt_q, nxt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   shift_q, shift_d;
  logic                    fd_q, fd_d;
  logic [IDX_W-1:0]        seek_incl, seek_excl;

  // Wraps at NUM_DIGITS-1 explicitly so non-power-of-two digit counts stay in range.
  function automatic logic [IDX_W-1:0] seek(input logic [IDX_W-1:0] from,
                                            input logic d,
                                            input logic [NUM_DIGITS-1:0] en,
                                            input logic incl);
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] ci;
    logic             found;
    int               c;
    int               step;
    res   = from;
    found = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      step = incl ? k : k + 1;
      if (!d) begin
        c = int'(from) + step;
        if (c >= NUM_DIGITS) c = c - NUM_DIGITS;
      end else begin
        c = int'(from) - step;
        if (c < 0) c = c + NUM_DIGITS;
      end
      ci = IDX_W'(c);
      if (!found && en[ci]) begin
        found = 1'b1;
        res   = ci;
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nxt_d     = nxt_q;
    cnt_d     = cnt_q;
    fd_d      = 1'b0;
    seek_incl = seek(idx_q, dir, digit_en, 1'b1);
    seek_excl = seek(idx_q, dir, digit_en, 1'b0);
    case (state_q)
      OFF: begin
        if (|digit_en) begin
          state_d = SHOW;
          idx_d   = seek_incl;
        end
      end
      SHOW: begin
        if (!digit_en[idx_q]) begin
          state_d = OFF;
        end else if (tickin) begin
          fd_d = dir ? (seek_excl >= idx_q) : (seek_excl <= idx_q);
          if (BLANK_CYCLES == 0) begin
            idx_d = seek_excl;
          end else begin
            state_d = BLANK;
            nxt_d   = seek_excl;
            cnt_d   = CNT_W'(BLANK_CYCLES - 1);
          end
        end
      end
      BLANK: begin
        if (cnt_q == '0) begin
          // Mask is re-sampled here so a digit disabled during blanking is never lit.
          if (digit_en[nxt_q]) begin
            state_d = SHOW;
            idx_d   = nxt_q;
          end else begin
            state_d = OFF;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = OFF;
    endcase
    shift_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (state_d == SHOW && idx_d == IDX_W'(i)) shift_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OFF;
      idx_q   <= '0;
      nxt_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_data = digits[i*DATA_W +: DATA_W];
    end
  end

  assign shift      = shift_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: default 8-digit scanner, a 3-cycle blanking variant and a
// 5-digit variant for non-power-of-two wrap.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        tick_a, dir_a, fd_a;
  logic [7:0]  en_a, shift_a;
  logic [31:0] dig_a;
  logic [2:0]  idx_a;
  logic [3:0]  data_a;

  logic        tick_b, dir_b, fd_b;
  logic [7:0]  en_b, shift_b;
  logic [2:0]  idx_b;
  logic [3:0]  data_b;

  logic        tick_c, dir_c, fd_c;
  logic [4:0]  en_c, shift_c;
  logic [19:0] dig_c;
  logic [2:0]  idx_c;
  logic [3:0]  data_c;

  seg_scan_ctrl dut_a (
    .clk(clk), .reset(rst), .tickin(tick_a), .dir(dir_a), .digit_en(en_a),
    .digits(dig_a), .shift(shift_a), .digit_idx(idx_a), .cur_data(data_a),
    .frame_done(fd_a));

  seg_scan_ctrl #(.BLANK_CYCLES(3)) dut_b (
    .clk(clk), .reset(rst), .tickin(tick_b), .dir(dir_b), .digit_en(en_b),
    .digits(dig_a), .shift(shift_b), .digit_idx(idx_b), .cur_data(data_b),
    .frame_done(fd_b));

  seg_scan_ctrl #(.NUM_DIGITS(5)) dut_c (
    .clk(clk), .reset(rst), .tickin(tick_c), .dir(dir_c), .digit_en(en_c),
    .digits(dig_c), .shift(shift_c), .digit_idx(idx_c), .cur_data(data_c),
    .frame_done(fd_c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       tick;
    logic       dir;
    logic [7:0] en;
    logic [2:0] idx;
    logic [7:0] shift;
    logic       fd;
  } vec_t;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] shift;
    logic       fd;
  } exp_t;

  vec_t vecs[20];
  exp_t sb_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       e;
    logic [4:0] exp_sc;
    logic [2:0] exp_ic;

    vecs[0]  = '{1'b1, 1'b0, 8'hFF, 3'd1, 8'hFD, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'hFF, 3'd2, 8'hFB, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'hFF, 3'd3, 8'hF7, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'hFF, 3'd4, 8'hEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'hFF, 3'd5, 8'hDF, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'hFF, 3'd6, 8'hBF, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'hFF, 3'd7, 8'h7F, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'hFE, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'hFF, 3'd7, 8'h7F, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 8'hFF, 3'd6, 8'hBF, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'hFF, 3'd7, 8'h7F, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'hFF, 3'd0, 8'hFE, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 8'h25, 3'd2, 8'hFB, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 8'h25, 3'd5, 8'hDF, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 8'h25, 3'd0, 8'hFE, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 8'h25, 3'd2, 8'hFB, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 8'h25, 3'd0, 8'hFE, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 8'h25, 3'd5, 8'hDF, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 8'h25, 3'd0, 8'hFE, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 8'h25, 3'd2, 8'hFB, 1'b0};

    rst = 1'b1;
    tick_a = 1'b0; dir_a = 1'b0; en_a = 8'hFF; dig_a = 32'h8A3C_5E71;
    tick_b = 1'b0; dir_b = 1'b0; en_b = 8'hFF;
    tick_c = 1'b0; dir_c = 1'b0; en_c = 5'h1F; dig_c = 20'h9B1F4;

    // Reset and first displayed digit
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_shift", shift_a, 8'hFF);
    chk("rst_idx", idx_a, 0);
    chk("rst_fd", fd_a, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_shift", shift_a, 8'hFF);
    @(posedge clk); #1;
    chk("first_shift", shift_a, 8'hFE);
    chk("first_idx", idx_a, 0);
    chk("first_data", data_a, dig_a[3:0]);
    chk("first_shift_b", shift_b, 8'hFE);
    chk("first_shift_c", shift_c, 5'h1E);

    // Table-driven ticks through the scoreboard
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dir_a  = vecs[i].dir;
      en_a   = vecs[i].en;
      tick_a = vecs[i].tick;
      sb_q.push_back('{vecs[i].idx, vecs[i].shift, vecs[i].fd});
      @(posedge clk); #1;
      tick_a = 1'b0;
      e = sb_q.pop_front();
      chk($sformatf("tbl%0d_idx", i), idx_a, e.idx);
      chk($sformatf("tbl%0d_shift", i), shift_a, e.shift);
      chk($sformatf("tbl%0d_fd", i), fd_a, e.fd);
      chk($sformatf("tbl%0d_data", i), data_a, dig_a[e.idx*4 +: 4]);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_fd_idle", i), fd_a, 0);
    end

    // Current digit disabled while shown: anodes off, then re-seek forward
    @(negedge clk);
    en_a = 8'h21;
    @(posedge clk); #1;
    chk("mask_off_shift", shift_a, 8'hFF);
    chk("mask_off_fd", fd_a, 0);
    @(posedge clk); #1;
    chk("mask_seek_idx", idx_a, 5);
    chk("mask_seek_shift", shift_a, 8'hDF);
    chk("mask_seek_data", data_a, dig_a[23:20]);

    // Empty mask: display off, ticks ignored
    @(negedge clk);
    en_a = 8'h00;
    @(posedge clk); #1;
    chk("empty_shift", shift_a, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tick_a = 1'b1;
      @(posedge clk); #1;
      tick_a = 1'b0;
      chk($sformatf("empty_tick%0d_shift", i), shift_a, 8'hFF);
      chk($sformatf("empty_tick%0d_fd", i), fd_a, 0);
    end
    chk("empty_idx", idx_a, 5);

    // Single enabled digit: every tick wraps
    @(negedge clk);
    en_a = 8'h10;
    @(posedge clk); #1;
    chk("single_shift", shift_a, 8'hEF);
    chk("single_idx", idx_a, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tick_a = 1'b1;
      dir_a  = i[0];
      @(posedge clk); #1;
      tick_a = 1'b0;
      chk($sformatf("single_tick%0d_fd", i), fd_a, 1);
      chk($sformatf("single_tick%0d_idx", i), idx_a, 4);
      chk($sformatf("single_tick%0d_shift", i), shift_a, 8'hEF);
    end
    @(posedge clk); #1;
    chk("single_fd_clear", fd_a, 0);

    // Blanking: 3 dark cycles, tick inside blanking dropped
    @(negedge clk);
    tick_b = 1'b1;
    @(posedge clk); #1;
    tick_b = 1'b0;
    chk("blank_e0_shift", shift_b, 8'hFF);
    chk("blank_e0_idx", idx_b, 0);
    chk("blank_e0_fd", fd_b, 0);
    @(negedge clk);
    tick_b = 1'b1;
    @(posedge clk); #1;
    tick_b = 1'b0;
    chk("blank_e1_shift", shift_b, 8'hFF);
    @(posedge clk); #1;
    chk("blank_e2_shift", shift_b, 8'hFF);
    @(posedge clk); #1;
    chk("blank_exit_shift", shift_b, 8'hFD);
    chk("blank_exit_idx", idx_b, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("blank_drop_idx", idx_b, 1);
    chk("blank_drop_shift", shift_b, 8'hFD);

    // dir change during blanking does not alter the held next digit
    @(negedge clk);
    tick_b = 1'b1;
    @(posedge clk); #1;
    tick_b = 1'b0;
    @(negedge clk);
    dir_b = 1'b1;
    @(posedge clk); #1;
    chk("blank_dir_e1_shift", shift_b, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    chk("blank_dir_idx", idx_b, 2);
    chk("blank_dir_shift", shift_b, 8'hFB);

    // Five digits: wrap at 4, not 7
    exp_ic = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      tick_c = 1'b1;
      dir_c  = 1'b0;
      @(posedge clk); #1;
      tick_c = 1'b0;
      exp_ic = (exp_ic == 3'd4) ? 3'd0 : exp_ic + 3'd1;
      exp_sc = ~(5'b00001 << exp_ic);
      chk($sformatf("n5_fwd%0d_idx", k), idx_c, exp_ic);
      chk($sformatf("n5_fwd%0d_shift", k), shift_c, exp_sc);
      chk($sformatf("n5_fwd%0d_fd", k), fd_c, (k == 5) ? 1 : 0);
      chk($sformatf("n5_fwd%0d_data", k), data_c, dig_c[exp_ic*4 +: 4]);
    end
    @(negedge clk);
    tick_c = 1'b1;
    dir_c  = 1'b1;
    @(posedge clk); #1;
    tick_c = 1'b0;
    chk("n5_rev_idx", idx_c, 4);
    chk("n5_rev_shift", shift_c, 5'h0F);
    chk("n5_rev_fd", fd_c, 1);

    // Reset mid-blanking while frame_done is high
    @(negedge clk);
    en_b   = 8'h04;
    tick_b = 1'b1;
    @(posedge clk); #1;
    tick_b = 1'b0;
    chk("rstb_fd_before", fd_b, 1);
    chk("rstb_shift_before", shift_b, 8'hFF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstb_shift", shift_b, 8'hFF);
    chk("rstb_idx", idx_b, 0);
    chk("rstb_fd", fd_b, 0);
    chk("rsta_idx", idx_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rstb_after_shift", shift_b, 8'hFB);
    chk("rstb_after_idx", idx_b, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
